// File: rtl/oled_init_sequencer.sv
// rtl/oled_init_sequencer.sv - OLED panel power-up command sequencer feeding a byte SPI transmitter
// Optional display-clear stage before display-on is enabled by defining OLED_INIT_CLEAR_EN.
module oled_init_sequencer #(
    parameter int unsigned CLOCK_FREQUENCY_HZ = 200000000,
    parameter int unsigned DEBUG              = 0
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       power_done,
    input  logic       tx_ready,
    input  logic       tx_idle,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       dc_c,
    output logic       vss_en,
    output logic       busy,
    output logic       init_done
);

    localparam logic [31:0] TICK_DIV    = (CLOCK_FREQUENCY_HZ < 1000000) ? 32'd1
                                          : 32'(CLOCK_FREQUENCY_HZ / 1000000);
    localparam logic [31:0] VCC_WAIT_US = (DEBUG != 0) ? 32'd10 : 32'd100000;
    localparam logic [5:0]  INIT_LAST   = 6'd38;
    localparam logic [7:0]  DISPLAY_ON  = 8'hAF;

    typedef enum logic [3:0] {
        IDLE,
        SEND_INIT,
        DRAIN_INIT,
        VCC_ON,
        WAIT_VCC,
        CLEAR,
        SEND_ON,
        DRAIN_ON,
        DONE
    } state_t;

    state_t      state;
    logic [5:0]  idx;
    logic [31:0] timer;
    logic [31:0] tick_cnt;
    logic        pd_q;
    logic        start;
    logic        us_tick;

    assign start   = power_done & ~pd_q;
    assign us_tick = (tick_cnt == TICK_DIV - 32'd1);

    function automatic logic [7:0] init_byte(input logic [5:0] i);
        case (i)
            6'd0:  init_byte = 8'hFD;  6'd1:  init_byte = 8'h12;  6'd2:  init_byte = 8'hAE;
            6'd3:  init_byte = 8'hA0;  6'd4:  init_byte = 8'h72;  6'd5:  init_byte = 8'hA1;
            6'd6:  init_byte = 8'h00;  6'd7:  init_byte = 8'hA2;  6'd8:  init_byte = 8'h00;
            6'd9:  init_byte = 8'hA4;  6'd10: init_byte = 8'hA8;  6'd11: init_byte = 8'h3F;
            6'd12: init_byte = 8'hAD;  6'd13: init_byte = 8'h8E;  6'd14: init_byte = 8'hB0;
            6'd15: init_byte = 8'h0B;  6'd16: init_byte = 8'hB1;  6'd17: init_byte = 8'h31;
            6'd18: init_byte = 8'hB3;  6'd19: init_byte = 8'hF0;  6'd20: init_byte = 8'h8A;
            6'd21: init_byte = 8'h64;  6'd22: init_byte = 8'h8B;  6'd23: init_byte = 8'h78;
            6'd24: init_byte = 8'h8C;  6'd25: init_byte = 8'h64;  6'd26: init_byte = 8'hBB;
            6'd27: init_byte = 8'h3A;  6'd28: init_byte = 8'hBE;  6'd29: init_byte = 8'h3E;
            6'd30: init_byte = 8'h87;  6'd31: init_byte = 8'h06;  6'd32: init_byte = 8'h81;
            6'd33: init_byte = 8'h91;  6'd34: init_byte = 8'h82;  6'd35: init_byte = 8'h50;
            6'd36: init_byte = 8'h83;  6'd37: init_byte = 8'h7D;  6'd38: init_byte = 8'h2E;
            default: init_byte = 8'h00;
        endcase
    endfunction

`ifdef OLED_INIT_CLEAR_EN
    localparam logic [5:0] CLEAR_LAST = 6'd4;
    logic clr_drain;

    // Clear-window command over the full 96x64 panel.
    function automatic logic [7:0] clear_byte(input logic [5:0] i);
        case (i)
            6'd0:    clear_byte = 8'h25;
            6'd1:    clear_byte = 8'h00;
            6'd2:    clear_byte = 8'h00;
            6'd3:    clear_byte = 8'h5F;
            6'd4:    clear_byte = 8'h3F;
            default: clear_byte = 8'h00;
        endcase
    endfunction
`endif

    // Microsecond prescaler restarts on VCC_ON so the rail settle time is whole ticks.
    always_ff @(posedge sclk) begin
        if (rst || state == VCC_ON) begin
            tick_cnt <= 32'd0;
        end else if (us_tick) begin
            tick_cnt <= 32'd0;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 6'd0;
            timer     <= 32'd0;
            pd_q      <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            dc_c      <= 1'b0;
            vss_en    <= 1'b0;
            busy      <= 1'b0;
            init_done <= 1'b0;
`ifdef OLED_INIT_CLEAR_EN
            clr_drain <= 1'b0;
`endif
        end else begin
            pd_q <= power_done;
            dc_c <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= SEND_INIT;
                        idx       <= 6'd0;
                        tx_valid  <= 1'b1;
                        tx_data   <= init_byte(6'd0);
                        busy      <= 1'b1;
                        init_done <= 1'b0;
                        vss_en    <= 1'b0;
                    end
                end
                SEND_INIT: begin
                    if (tx_valid && tx_ready) begin
                        if (idx == INIT_LAST) begin
                            tx_valid <= 1'b0;
                            state    <= DRAIN_INIT;
                        end else begin
                            idx     <= idx + 6'd1;
                            tx_data <= init_byte(idx + 6'd1);
                        end
                    end
                end
                DRAIN_INIT: begin
                    if (tx_idle) begin
                        state <= VCC_ON;
                    end
                end
                VCC_ON: begin
                    vss_en <= 1'b1;
                    timer  <= VCC_WAIT_US;
                    state  <= WAIT_VCC;
                end
                WAIT_VCC: begin
                    if (us_tick) begin
                        if (timer <= 32'd1) begin
                            timer    <= 32'd0;
                            tx_valid <= 1'b1;
`ifdef OLED_INIT_CLEAR_EN
                            state     <= CLEAR;
                            idx       <= 6'd0;
                            clr_drain <= 1'b0;
                            tx_data   <= clear_byte(6'd0);
`else
                            state   <= SEND_ON;
                            tx_data <= DISPLAY_ON;
`endif
                        end else begin
                            timer <= timer - 32'd1;
                        end
                    end
                end
`ifdef OLED_INIT_CLEAR_EN
                CLEAR: begin
                    if (!clr_drain) begin
                        if (tx_valid && tx_ready) begin
                            if (idx == CLEAR_LAST) begin
                                tx_valid  <= 1'b0;
                                clr_drain <= 1'b1;
                            end else begin
                                idx     <= idx + 6'd1;
                                tx_data <= clear_byte(idx + 6'd1);
                            end
                        end
                    end else if (tx_idle) begin
                        clr_drain <= 1'b0;
                        state     <= SEND_ON;
                        tx_valid  <= 1'b1;
                        tx_data   <= DISPLAY_ON;
                    end
                end
`endif
                SEND_ON: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= DRAIN_ON;
                    end
                end
                DRAIN_ON: begin
                    if (tx_idle) begin
                        state     <= DONE;
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_init_sequencer.sv
// tb/tb_oled_init_sequencer.sv - self-checking bench for oled_init_sequencer against a transaction-level model
// Honours OLED_INIT_CLEAR_EN the same way as the design.
module tb_oled_init_sequencer;

    localparam int CLK_HZ   = 20000000;
    localparam int WAIT_CYC = (CLK_HZ / 1000000) * 10;
`ifdef OLED_INIT_CLEAR_EN
    localparam int CLR_N = 5;
`else
    localparam int CLR_N = 0;
`endif
    localparam int TOTAL = 39 + CLR_N + 1;

    logic       sclk = 1'b0;
    logic       rst = 1'b1;
    logic       power_done = 1'b0;
    logic       tx_ready = 1'b1;
    logic       tx_idle = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid, dc_c, vss_en, busy, init_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    oled_init_sequencer #(.CLOCK_FREQUENCY_HZ(CLK_HZ), .DEBUG(1)) dut (
        .sclk(sclk), .rst(rst), .power_done(power_done), .tx_ready(tx_ready), .tx_idle(tx_idle),
        .tx_data(tx_data), .tx_valid(tx_valid), .dc_c(dc_c), .vss_en(vss_en), .busy(busy),
        .init_done(init_done)
    );

    always #5 sclk = ~sclk;

    logic [7:0] init_tab [0:38] = '{
        8'hFD, 8'h12, 8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4,
        8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31, 8'hB3, 8'hF0,
        8'h8A, 8'h64, 8'h8B, 8'h78, 8'h8C, 8'h64, 8'hBB, 8'h3A, 8'hBE, 8'h3E,
        8'h87, 8'h06, 8'h81, 8'h91, 8'h82, 8'h50, 8'h83, 8'h7D, 8'h2E};
    logic [7:0] clr_tab [0:4] = '{8'h25, 8'h00, 8'h00, 8'h5F, 8'h3F};
    logic       bp_pat [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: phase 0 idle/done, 1 init bytes, 2 drain, 3 rail enable, 4 settle, 5 tail bytes, 6 final drain
    logic [7:0] exp_q [$];
    logic [7:0] xfer_log [$];
    bit         started = 0, active = 0, rst_chk = 0, stall_prev = 0, prev_pd = 0;
    logic [7:0] stall_data;
    int         phase = 0, init_left = 0, vss_cyc = 0, wait_meas = -1;
    int         first_init_cyc = 0, last_init_cyc = 0;
    logic       exp_busy = 0, exp_done = 0, exp_vss = 0;

    task automatic load_expected();
        exp_q.delete();
        foreach (init_tab[i]) exp_q.push_back(init_tab[i]);
        if (CLR_N != 0) foreach (clr_tab[i]) exp_q.push_back(clr_tab[i]);
        exp_q.push_back(8'hAF);
    endtask

    always @(negedge sclk) begin
        bit st;
        cyc++;
        if (started) begin
            chk_eq("dc_c", dc_c, 0);
            chk_eq("busy", busy, exp_busy);
            chk_eq("init_done", init_done, exp_done);
            chk_eq("vss_en", vss_en, exp_vss);
            if (rst_chk) begin
                chk_eq("rst_tx_valid", tx_valid, 0);
                chk_eq("rst_tx_data", tx_data, 0);
            end
            if (stall_prev) begin
                chk_eq("stall_valid", tx_valid, 1);
                chk_eq("stall_data", tx_data, stall_data);
            end
        end
        if (rst) begin
            started = 1; rst_chk = 1; stall_prev = 0; active = 0; phase = 0; prev_pd = 0;
            exp_busy = 0; exp_done = 0; exp_vss = 0;
            exp_q.delete();
        end else begin
            rst_chk = 0;
            st = power_done && !prev_pd;
            prev_pd = power_done;
            if (st && !active) begin
                active = 1; phase = 1; init_left = 39;
                exp_busy = 1; exp_done = 0; exp_vss = 0;
                load_expected();
            end else if (active) begin
                if (phase == 2 && tx_idle) phase = 3;
                else if (phase == 3) begin exp_vss = 1; vss_cyc = cyc + 1; phase = 4; end
                else if (phase == 4) begin
                    if (tx_valid) begin
                        wait_meas = cyc - vss_cyc;
                        chk_eq("wait_len", wait_meas, WAIT_CYC);
                        phase = 5;
                    end else if (cyc - vss_cyc > WAIT_CYC + 8) begin
                        chk_eq("wait_timeout", cyc - vss_cyc, WAIT_CYC);
                        phase = 5;
                    end
                end else if (phase == 6 && tx_idle) begin
                    exp_done = 1; exp_busy = 0; active = 0; phase = 0;
                end
                if (tx_valid && phase != 1 && phase != 5) chk_eq("spurious_valid", tx_valid, 0);
                if (tx_valid && tx_ready && (phase == 1 || phase == 5)) begin
                    if (exp_q.size() == 0) chk_eq("xfer_extra", exp_q.size(), 1);
                    else chk_eq("xfer_data", tx_data, exp_q.pop_front());
                    xfer_log.push_back(tx_data);
                    if (phase == 1) begin
                        if (init_left == 39) first_init_cyc = cyc;
                        init_left--;
                        if (init_left == 0) begin last_init_cyc = cyc; phase = 2; end
                    end else if (exp_q.size() == 0) phase = 6;
                end
            end else if (tx_valid) begin
                chk_eq("spurious_valid", tx_valid, 0);
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    bit bp_mode = 0, idle_hold = 0;
    initial begin
        int k = 0;
        forever begin
            @(posedge sclk);
            #1;
            tx_ready = bp_mode ? bp_pat[k % 4] : 1'b1;
            tx_idle  = !idle_hold;
            k++;
        end
    end

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic pulse_start();
        power_done = 1'b1;
        step();
        power_done = 1'b0;
        step();
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!init_done && n < budget) begin step(); n++; end
        chk_eq(name, init_done, 1);
    endtask

    initial begin
        int n;
        bit vss_seen;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk_eq("reset_busy", busy, 0);
        chk_eq("reset_vss", vss_en, 0);
        chk_eq("reset_done", init_done, 0);
        chk_eq("reset_valid", tx_valid, 0);
        chk_eq("reset_data", tx_data, 0);

        // Full sequence, no backpressure
        xfer_log.delete();
        pulse_start();
        chk_eq("t1_busy", busy, 1);
        wait_done(1000, "t1_done");
        chk_eq("t1_count", xfer_log.size(), TOTAL);
        if (xfer_log.size() == TOTAL) begin
            chk_eq("t1_first", xfer_log[0], 8'hFD);
            chk_eq("t1_last_init", xfer_log[38], 8'h2E);
            chk_eq("t1_after_wait", xfer_log[39], (CLR_N != 0) ? 8'h25 : 8'hAF);
            chk_eq("t1_last", xfer_log[TOTAL-1], 8'hAF);
        end
        chk_eq("t1_burst", last_init_cyc - first_init_cyc, 38);
        chk_eq("t1_wait", wait_meas, 200);
        chk_eq("t1_busy_end", busy, 0);

        // Restart from DONE with tx_ready pattern 1,0,0,1
        bp_mode = 1;
        xfer_log.delete();
        pulse_start();
        chk_eq("t2_vss_drop", vss_en, 0);
        chk_eq("t2_done_drop", init_done, 0);
        wait_done(2000, "t2_done");
        bp_mode = 0;
        chk_eq("t2_count", xfer_log.size(), TOTAL);
        if (xfer_log.size() == TOTAL) chk_eq("t2_mid", xfer_log[20], 8'h8A);

        // Second start edge during the rail settle wait is ignored
        xfer_log.delete();
        pulse_start();
        n = 0;
        while (!vss_en && n < 300) begin step(); n++; end
        chk_eq("t3_vss_up", vss_en, 1);
        repeat (20) step();
        pulse_start();
        chk_eq("t3_still_vss", vss_en, 1);
        wait_done(1000, "t3_done");
        repeat (50) step();
        chk_eq("t3_count", xfer_log.size(), TOTAL);
        chk_eq("t3_done_hold", init_done, 1);

        // Reset at byte index 20, then replay
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        xfer_log.delete();
        pulse_start();
        n = 0;
        while (xfer_log.size() < 20 && n < 100) begin step(); n++; end
        chk_eq("t4_reached20", xfer_log.size(), 20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_eq("t4_rst_valid", tx_valid, 0);
        chk_eq("t4_rst_data", tx_data, 0);
        chk_eq("t4_rst_busy", busy, 0);
        chk_eq("t4_rst_vss", vss_en, 0);
        step();
        xfer_log.delete();
        pulse_start();
        wait_done(1000, "t4_done");
        chk_eq("t4_count", xfer_log.size(), TOTAL);
        if (xfer_log.size() == TOTAL) chk_eq("t4_replay_first", xfer_log[0], 8'hFD);

        // tx_idle held low for 50 cycles after the last init byte
        idle_hold = 1;
        xfer_log.delete();
        pulse_start();
        n = 0;
        while (xfer_log.size() < 39 && n < 200) begin step(); n++; end
        chk_eq("t5_init_sent", xfer_log.size(), 39);
        vss_seen = 0;
        repeat (50) begin step(); if (vss_en) vss_seen = 1; end
        chk_eq("t5_vss_gated", vss_seen, 0);
        idle_hold = 0;
        n = 0;
        while (!vss_en && n < 10) begin step(); n++; end
        chk_eq("t5_vss_up", vss_en, 1);
        wait_done(1000, "t5_done");
        chk_eq("t5_count", xfer_log.size(), TOTAL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
